reel_renderer: RTL and testbench



---
 rtl/reel_renderer.sv | 223 ++++++++++++++++++++++
 tb/tb_reel_renderer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reel_renderer.sv
// reel_renderer
//   Maps the VGA raster onto three vertically scrolling reel windows, drives
//   the sprite ROM address (symbol + x/y inside the 64x64 sprite), and turns
//   the ROM pixel returned one cycle later into a 3-bit RGB stream whose syncs
//   and video_on are delayed to line up with it. Also holds the per-reel
//   spin/stop animation, stepped once per frame_tick.
//
//   Optional feature: define REEL_PAYLINE_EN to paint row 32 of every reel
//   window red (3'b100) as a payline overlay.
//
// Ports
//   clk, reset_n                     pixel clock, async active-low reset
//   hcount, vcount, video_on         raster position / active-video flag
//   hsync_in, vsync_in               raw syncs
//   frame_tick, spin_start           frame pulse, spin request
//   target0..2                       stop symbol per reel (7 treated as 6)
//   pixel_rgb                        ROM pixel, one cycle after the address
//   sprite_idx, x/y_in_sprite        ROM address (registered)
//   rgb_out, hsync_out, vsync_out,
//   video_on_out                     output pixel stream, 3 cycles after raster
//   busy, done                       any reel animating / last reel stopped
module reel_renderer #(
  parameter int unsigned REEL_X0    = 128,
  parameter int unsigned REEL_Y0    = 208,
  parameter int unsigned REEL_GAP   = 16,
  parameter int unsigned SPEED      = 8,
  parameter int unsigned MIN_FRAMES = 60,
  parameter int unsigned STAGGER    = 20,
  parameter logic [2:0]  BG_RGB     = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       frame_tick,
  input  logic       spin_start,
  input  logic [2:0] target0,
  input  logic [2:0] target1,
  input  logic [2:0] target2,
  input  logic [2:0] pixel_rgb,
  output logic [2:0] sprite_idx,
  output logic [5:0] x_in_sprite,
  output logic [5:0] y_in_sprite,
  output logic [2:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       video_on_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned STRIP_ROWS = 448;   // 7 symbols x 64 rows
  localparam int unsigned WIN        = 64;
  localparam int unsigned PITCH      = WIN + REEL_GAP;

  typedef enum logic [1:0] {IDLE, SPIN, STOPPING, STOPPED} reel_state_t;

  logic [8:0] target_all;
  logic [2:0] hit;
  logic [2:0] active_vec;
  logic [2:0] stopped_next;
  logic [26:0] row_flat;     // 9-bit strip row per reel
  logic [17:0] x_flat;       // 6-bit window x offset per reel
  logic        in_rows;
  logic [5:0]  row_off;
  logic        spin_accept;

  assign target_all  = {target2, target1, target0};
  assign in_rows     = (vcount >= 10'(REEL_Y0)) && (vcount < 10'(REEL_Y0 + WIN));
  assign row_off     = 6'(vcount - 10'(REEL_Y0));
  assign busy        = |active_vec;
  assign spin_accept = spin_start && !busy;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_reel
    localparam int unsigned X_LO        = REEL_X0 + gi * PITCH;
    localparam logic [7:0]  STOP_FRAMES = 8'(MIN_FRAMES + gi * STAGGER);

    reel_state_t state_reg, state_next;
    logic [8:0]  pos_reg, pos_next;
    logic [7:0]  frames_reg, frames_next;
    logic [2:0]  target_reg, target_next;
    logic [8:0]  pos_step;
    logic [9:0]  row_sum;
    logic [2:0]  target_in;

    assign hit[gi] = in_rows && (hcount >= 10'(X_LO)) && (hcount < 10'(X_LO + WIN));
    assign x_flat[gi*6 +: 6] = 6'(hcount - 10'(X_LO));

    // Strip row under this raster line, wrapped onto the 448-row strip.
    assign row_sum = {1'b0, pos_reg} + {4'b0, row_off};
    assign row_flat[gi*9 +: 9] = (row_sum >= 10'(STRIP_ROWS)) ?
                                 9'(row_sum - 10'(STRIP_ROWS)) : row_sum[8:0];

    assign pos_step = (pos_reg >= 9'(STRIP_ROWS - SPEED)) ?
                      pos_reg - 9'(STRIP_ROWS - SPEED) : pos_reg + 9'(SPEED);

    // Symbol 7 does not exist on the strip; clamp to the last symbol.
    assign target_in = (target_all[gi*3 +: 3] == 3'd7) ? 3'd6 : target_all[gi*3 +: 3];

    assign active_vec[gi]   = (state_reg == SPIN) || (state_reg == STOPPING);
    assign stopped_next[gi] = (state_next == STOPPED);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg  <= IDLE;
        pos_reg    <= '0;
        frames_reg <= '0;
        target_reg <= '0;
      end else begin
        state_reg  <= state_next;
        pos_reg    <= pos_next;
        frames_reg <= frames_next;
        target_reg <= target_next;
      end
    end

    // An accepted spin wins over a coincident tick: stepping starts next tick.
    always_comb begin
      state_next  = state_reg;
      pos_next    = pos_reg;
      frames_next = frames_reg;
      target_next = target_reg;
      if (spin_accept) begin
        state_next  = SPIN;
        frames_next = '0;
        target_next = target_in;
      end else if (frame_tick) begin
        case (state_reg)
          SPIN: begin
            pos_next    = pos_step;
            frames_next = frames_reg + 8'd1;
            if (frames_reg + 8'd1 == STOP_FRAMES) state_next = STOPPING;
          end
          STOPPING: begin
            pos_next = pos_step;
            // SPEED divides 64, so the symbol boundary is landed on exactly.
            if (pos_step == {target_reg, 6'd0}) state_next = STOPPED;
          end
          default: ;
        endcase
      end
    end
  end

  // Windows never overlap, so at most one reel contributes the address.
  logic [8:0] sel_row;
  logic [5:0] sel_x;
  logic       any_hit;
  always_comb begin
    sel_row = '0;
    sel_x   = '0;
    any_hit = |hit;
    for (int i = 0; i < 3; i++) begin
      if (hit[i]) begin
        sel_row = row_flat[i*9 +: 9];
        sel_x   = x_flat[i*6 +: 6];
      end
    end
  end

  logic hit_d1, hit_d2, vid_d1, vid_d2, hs_d1, hs_d2, vs_d1, vs_d2;
`ifdef REEL_PAYLINE_EN
  logic pay_d1, pay_d2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pay_d1 <= 1'b0;
      pay_d2 <= 1'b0;
    end else begin
      pay_d1 <= any_hit && (row_off == 6'd32);
      pay_d2 <= pay_d1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_idx   <= '0;
      x_in_sprite  <= '0;
      y_in_sprite  <= '0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      vid_d1       <= 1'b0;
      vid_d2       <= 1'b0;
      hs_d1        <= 1'b0;
      hs_d2        <= 1'b0;
      vs_d1        <= 1'b0;
      vs_d2        <= 1'b0;
      rgb_out      <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
      done         <= 1'b0;
    end else begin
      sprite_idx   <= any_hit ? sel_row[8:6] : 3'd0;
      x_in_sprite  <= any_hit ? sel_x        : 6'd0;
      y_in_sprite  <= any_hit ? sel_row[5:0] : 6'd0;
      hit_d1       <= any_hit;
      hit_d2       <= hit_d1;
      vid_d1       <= video_on;
      vid_d2       <= vid_d1;
      hs_d1        <= hsync_in;
      hs_d2        <= hs_d1;
      vs_d1        <= vsync_in;
      vs_d2        <= vs_d1;
      hsync_out    <= hs_d2;
      vsync_out    <= vs_d2;
      video_on_out <= vid_d2;
      if (!vid_d2)      rgb_out <= 3'd0;
`ifdef REEL_PAYLINE_EN
      else if (pay_d2)  rgb_out <= 3'b100;
`endif
      else if (hit_d2)  rgb_out <= pixel_rgb;
      else              rgb_out <= BG_RGB;
      // Pulses on the edge where the last animating reel lands.
      done         <= busy && (&stopped_next);
    end
  end

endmodule

// File: tb/tb_reel_renderer.sv
module tb_reel_renderer;
  localparam int X0 = 128, Y0 = 208, GAP = 16, SPD = 8, MINF = 60, STAG = 20;
  localparam logic [2:0] BG = 3'b000;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic [9:0] hcount = '0, vcount = '0;
  logic       video_on = 0, hsync_in = 0, vsync_in = 0, frame_tick = 0, spin_start = 0;
  logic [2:0] target0 = 0, target1 = 0, target2 = 0, pixel_rgb = 0;
  logic [2:0] sprite_idx, rgb_out;
  logic [5:0] x_in_sprite, y_in_sprite;
  logic       hsync_out, vsync_out, video_on_out, busy, done;

  always #5 clk = ~clk;

  reel_renderer dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_tick(frame_tick), .spin_start(spin_start),
    .target0(target0), .target1(target1), .target2(target2),
    .pixel_rgb(pixel_rgb), .sprite_idx(sprite_idx),
    .x_in_sprite(x_in_sprite), .y_in_sprite(y_in_sprite),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .video_on_out(video_on_out), .busy(busy), .done(done)
  );

  typedef struct {
    logic [2:0] idx;
    logic [5:0] xs, ys;
    logic [2:0] rgb;
    logic       hs, vs, von, bsy, dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  bit   rst_hold = 1;

  // Reference model: each reel is described by its position at spin start,
  // ticks taken since then and the tick count at which it lands.
  int p0[3], kk[3], stop_at[3];
  bit active[3];
  bit hh_hit[2], hh_pay[2], hh_vid[2], hh_hs[2], hh_vs[2];

  function automatic int model_pos(int i);
    int k;
    if (!active[i]) return 0;
    k = (kk[i] < stop_at[i]) ? kk[i] : stop_at[i];
    return (p0[i] + SPD * k) % 448;
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < 3; i++)
      if (active[i] && kk[i] < stop_at[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // One raster cycle: drive inputs, update the model, queue the expectation.
  task automatic step(input bit tick, input bit spin, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c);
    exp_t e;
    bit   hit, pay, busy_now;
    int   h, v, r, s, xl, tgt, tstop, post, d;
    @(negedge clk);
    reset_n    = !rst_hold;
    h          = ($urandom % 10 < 8) ? $urandom_range(120, 360) : $urandom_range(0, 1023);
    v          = ($urandom % 10 < 8) ? $urandom_range(200, 280) : $urandom_range(0, 1023);
    hcount     = 10'(h);
    vcount     = 10'(v);
    video_on   = ($urandom % 8) != 0;
    hsync_in   = 1'($urandom);
    vsync_in   = 1'($urandom);
    pixel_rgb  = 3'($urandom);
    frame_tick = tick;
    spin_start = spin;
    target0 = a; target1 = b; target2 = c;
    e = '{default: '0};
    if (rst_hold) begin
      for (int i = 0; i < 3; i++) begin active[i] = 0; kk[i] = 0; p0[i] = 0; stop_at[i] = 0; end
      for (int j = 0; j < 2; j++) begin
        hh_hit[j] = 0; hh_pay[j] = 0; hh_vid[j] = 0; hh_hs[j] = 0; hh_vs[j] = 0;
      end
    end else begin
      hit = 0; pay = 0;
      for (int i = 0; i < 3; i++) begin
        xl = X0 + i * (64 + GAP);
        if (h >= xl && h < xl + 64 && v >= Y0 && v < Y0 + 64) begin
          hit   = 1;
          r     = v - Y0;
          s     = (model_pos(i) + r) % 448;
          e.idx = 3'(s / 64);
          e.ys  = 6'(s % 64);
          e.xs  = 6'(h - xl);
          pay   = (r == 32);
        end
      end
      // Colour for the raster sampled two cycles ago with today's ROM pixel.
      if (!hh_vid[1]) e.rgb = 3'd0;
`ifdef REEL_PAYLINE_EN
      else if (hh_pay[1]) e.rgb = 3'b100;
`endif
      else if (hh_hit[1]) e.rgb = pixel_rgb;
      else e.rgb = BG;
      e.hs  = hh_hs[1];
      e.vs  = hh_vs[1];
      e.von = hh_vid[1];
      hh_hit[1] = hh_hit[0]; hh_pay[1] = hh_pay[0]; hh_vid[1] = hh_vid[0];
      hh_hs[1]  = hh_hs[0];  hh_vs[1]  = hh_vs[0];
      hh_hit[0] = hit; hh_pay[0] = pay; hh_vid[0] = video_on;
      hh_hs[0]  = hsync_in; hh_vs[0] = vsync_in;

      busy_now = model_busy();
      if (spin && !busy_now) begin
        for (int i = 0; i < 3; i++) begin
          p0[i]  = model_pos(i);
          kk[i]  = 0;
          active[i] = 1;
          tgt    = (i == 0) ? int'(a) : (i == 1) ? int'(b) : int'(c);
          if (tgt == 7) tgt = 6;
          tstop  = MINF + STAG * i;
          post   = (p0[i] + SPD * tstop) % 448;
          d      = ((tgt * 64 - post + 448) % 448) / SPD;
          if (d == 0) d = 448 / SPD;   // already on target: needs a full turn
          stop_at[i] = tstop + d;
        end
      end else if (tick) begin
        for (int i = 0; i < 3; i++)
          if (active[i] && kk[i] < stop_at[i]) kk[i]++;
      end
      e.bsy = model_busy();
      e.dn  = busy_now && !e.bsy;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sprite_idx",   9'(sprite_idx),   9'(e.idx));
        chk("x_in_sprite",  9'(x_in_sprite),  9'(e.xs));
        chk("y_in_sprite",  9'(y_in_sprite),  9'(e.ys));
        chk("rgb_out",      9'(rgb_out),      9'(e.rgb));
        chk("hsync_out",    9'(hsync_out),    9'(e.hs));
        chk("vsync_out",    9'(vsync_out),    9'(e.vs));
        chk("video_on_out", 9'(video_on_out), 9'(e.von));
        chk("busy",         9'(busy),         9'(e.bsy));
        chk("done",         9'(done),         9'(e.dn));
        if (e.dn) $display("done pulse t=%0t", $time);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) step(0, 0, 3'($urandom), 3'($urandom), 3'($urandom));
  endtask

  task automatic run_spin(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input int lock_at, input int rst_at, input bit same_tick);
    int ticks = 0;
    int cyc   = 0;
    $display("spin targets=%0d,%0d,%0d t=%0t", a, b, c, $time);
    step(same_tick, 1, a, b, c);
    while (model_busy() && cyc < 3000) begin
      cyc++;
      if (cyc % 4 == 0) begin
        step(1, 0, 3'($urandom), 3'($urandom), 3'($urandom));
        ticks++;
      end else if (ticks == lock_at && cyc % 4 == 1) begin
        step(0, 1, 3'd0, 3'd0, 3'd0);          // must be ignored while busy
      end else if (ticks == 55 && cyc % 4 == 2) begin
        idle(30);                              // hold pos at 440 to exercise wrap
      end else begin
        idle(1);
      end
      if (ticks == rst_at && !rst_hold) begin
        rst_hold = 1;
        idle(3);
        rst_hold = 0;
      end
    end
    if (model_busy()) begin
      failures++;
      $display("FAIL spin_timeout actual=busy required=stopped t=%0t", $time);
    end
    idle(10);
  endtask

  initial begin
    rst_hold = 1;
    idle(6);
    rst_hold = 0;
    idle(40);
    run_spin(3'd3, 3'd5, 3'd1, 30, -1, 1'b0);
    run_spin(3'd7, 3'd7, 3'd7, -1, -1, 1'b1);
    run_spin(3'd2, 3'd4, 3'd6, -1, 30, 1'b0);
    idle(20);
    for (int n = 0; n < 4; n++)
      run_spin(3'($urandom), 3'($urandom), 3'($urandom), -1, -1, 1'($urandom));
    idle(5);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
